// File: rtl/x_lut5_cfg_loader_pkg.sv
// Shared definitions for the run-time reconfigurable 5-input LUT and its serial loader.
package x_lut5_cfg_loader_pkg;

  localparam int unsigned FrameBits = 32;
  localparam int unsigned AddrW     = 5;
  localparam int unsigned CntW      = $clog2(FrameBits);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StShift  = 2'd1,
    StCommit = 2'd2
  } state_e;

  // Binary mux tree on ?: operators. In a 4-state simulator an unknown select merges both
  // branches (equal -> that value, different -> X), so an X/Z address bit yields the common
  // value of all reachable entries, or X when they disagree. Synthesizes to a plain 32:1 mux.
  function automatic logic lut5_lookup(input logic [FrameBits-1:0] tbl,
                                       input logic [AddrW-1:0]     addr);
    logic [15:0] l1;
    logic [7:0]  l2;
    logic [3:0]  l3;
    logic [1:0]  l4;
    for (int k = 0; k < 16; k++) l1[k] = addr[0] ? tbl[2*k+1] : tbl[2*k];
    for (int k = 0; k < 8; k++)  l2[k] = addr[1] ? l1[2*k+1]  : l1[2*k];
    for (int k = 0; k < 4; k++)  l3[k] = addr[2] ? l2[2*k+1]  : l2[2*k];
    for (int k = 0; k < 2; k++)  l4[k] = addr[3] ? l3[2*k+1]  : l3[2*k];
    return addr[4] ? l4[1] : l4[0];
  endfunction

endpackage

// File: rtl/x_lut5_cfg_loader_if.sv
// Configuration and lookup signals of the LUT loader, grouped for port connection.
interface x_lut5_cfg_loader_if;
  import x_lut5_cfg_loader_pkg::*;

  logic             start;
  logic             ce;
  logic             cdi;
  logic [AddrW-1:0] adr;
  logic             o;
  logic             oq;
  logic             cdo;
  logic             busy;
  logic             done;

  modport master (
    output start, ce, cdi, adr,
    input  o, oq, cdo, busy, done
  );

  modport slave (
    input  start, ce, cdi, adr,
    output o, oq, cdo, busy, done
  );

endinterface

// File: rtl/x_lut5_eval.sv
// Combinational, X-pessimistic 5-input LUT evaluation of a 32-entry truth table.
module x_lut5_eval
  import x_lut5_cfg_loader_pkg::*;
(
  input  logic [FrameBits-1:0] tbl_i,
  input  logic [AddrW-1:0]     addr_i,
  output logic                 o_o
);

  assign o_o = lut5_lookup(tbl_i, addr_i);

endmodule

// File: rtl/x_lut5_cfg_loader.sv
// 5-input LUT with a bit-serial shadow loader; the active table updates atomically on commit.
module x_lut5_cfg_loader
  import x_lut5_cfg_loader_pkg::*;
#(
  parameter logic [FrameBits-1:0] Init = '0,
  parameter string                Loc  = "UNPLACED"
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  x_lut5_cfg_loader_if.slave     bus
);

  localparam logic [CntW-1:0] LastBit = CntW'(FrameBits - 1);

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [FrameBits-1:0]   shadow_q, shadow_d;
  logic [FrameBits-1:0]   active_q, active_d;
  logic                   oq_q;
  logic                   lut_o;

  // Placement annotation only; no hardware depends on it.
  if (Loc == "") begin : g_no_loc
  end

  // Loader state, counter and both table registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      shadow_q <= Init;
      active_q <= Init;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  // Next-state: START only counts in IDLE; the final accepted bit also writes active.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    active_d = active_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StShift;
          cnt_d   = '0;
        end
      end
      StShift: begin
        if (bus.ce) begin
          shadow_d = {shadow_q[FrameBits-2:0], bus.cdi};
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == LastBit) begin
            // Active takes the full frame including this edge's bit; cnt wraps here.
            active_d = {shadow_q[FrameBits-2:0], bus.cdi};
            state_d  = StCommit;
          end
        end
      end
      StCommit: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Registered copy of the combinational lookup.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      oq_q <= 1'b0;
    end else begin
      oq_q <= lut_o;
    end
  end

  x_lut5_eval u_eval (
    .tbl_i  (active_q),
    .addr_i (bus.adr),
    .o_o    (lut_o)
  );

  assign bus.o    = lut_o;
  assign bus.oq   = oq_q;
  assign bus.cdo  = shadow_q[FrameBits-1];
  assign bus.busy = (state_q != StIdle);
  assign bus.done = (state_q == StCommit);

endmodule

// File: tb/tb_x_lut5_cfg_loader.sv
// Self-checking bench for x_lut5_cfg_loader: vector tables, directed frames, random frames.
module tb_x_lut5_cfg_loader;

  localparam logic [31:0] InitVal = 32'hF0F0_1234;

  logic clk = 1'b0;
  logic rst_n;

  x_lut5_cfg_loader_if bus ();

  x_lut5_cfg_loader #(
    .Init (InitVal),
    .Loc  ("X0Y0")
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: tables, number of bits accepted in the current frame (-1 = no frame),
  // and a flag for the single commit cycle.
  logic [31:0] m_active;
  logic [31:0] m_shadow;
  int          m_bits;
  bit          m_commit;
  logic        m_oq;

  typedef struct {
    logic [4:0] adr;
    logic       exp_o;
  } vec_t;

  vec_t init_vecs [8];
  vec_t dead_vecs [8];

  // Common value over all entries reachable by resolving unknown address bits.
  function automatic logic ref_lookup(input logic [31:0] tbl, input logic [4:0] a);
    logic v;
    bit   seen;
    bit   reach;
    v    = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 32; i++) begin
      reach = 1'b1;
      for (int j = 0; j < 5; j++) begin
        if ((a[j] === 1'b0 && i[j]) || (a[j] === 1'b1 && !i[j])) reach = 1'b0;
      end
      if (reach) begin
        if (!seen) begin
          v    = tbl[i];
          seen = 1'b1;
        end else if (v !== tbl[i]) begin
          v = 1'bx;
        end
      end
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = InitVal;
    m_shadow = InitVal;
    m_bits   = -1;
    m_commit = 1'b0;
    m_oq     = 1'b0;
  endtask

  task automatic check_all();
    chk("o",    bus.o,    ref_lookup(m_active, bus.adr));
    chk("oq",   bus.oq,   m_oq);
    chk("busy", bus.busy, (m_bits >= 0));
    chk("done", bus.done, m_commit);
    chk("cdo",  bus.cdo,  m_shadow[31]);
  endtask

  // Advance model by one edge using the inputs currently driven, then sample the DUT.
  task automatic tick();
    logic o_now;
    o_now = ref_lookup(m_active, bus.adr);
    if (m_commit) begin
      m_commit = 1'b0;
      m_bits   = -1;
    end else if (m_bits < 0) begin
      if (bus.start) m_bits = 0;
    end else if (bus.ce) begin
      m_shadow = {m_shadow[30:0], bus.cdi};
      m_bits++;
      if (m_bits == 32) begin
        m_active = m_shadow;
        m_commit = 1'b1;
      end
    end
    m_oq = o_now;
    @(posedge clk);
    #1;
    check_all();
  endtask

  // mode 0: CE always high; 1: CE low every other cycle (low first); 2: random CE and START.
  task automatic send_frame(input logic [31:0] data, input int mode,
                            output int busy_cyc, output int done_cyc, output int shift_cyc);
    busy_cyc  = 0;
    done_cyc  = 0;
    shift_cyc = 0;
    bus.start = 1'b1;
    bus.ce    = 1'b0;
    tick();
    bus.start = 1'b0;
    if (bus.busy) busy_cyc++;
    for (int c = 0; c < 300 && m_bits >= 0 && !m_commit; c++) begin
      if (mode == 0) begin
        bus.ce = 1'b1;
      end else if (mode == 1) begin
        bus.ce = (c % 2 == 1);
      end else begin
        bus.ce    = ($urandom_range(0, 3) != 0);
        bus.start = $urandom_range(0, 1) != 0;
      end
      bus.cdi = data[31 - m_bits];
      bus.adr = 5'($urandom_range(0, 31));
      tick();
      shift_cyc++;
      if (bus.busy) busy_cyc++;
      if (bus.done) done_cyc++;
    end
    bus.ce    = 1'b0;
    bus.start = 1'b0;
    tick();
    if (bus.busy) busy_cyc++;
    if (bus.done) done_cyc++;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int bcyc, dcyc, scyc, idle_seen, done_seen;
    logic [31:0] rdata;
    logic [4:0]  xadr;

    // Hand-derived truth-table bits of INIT and of 32'hDEADBEEF.
    init_vecs = '{'{5'd0, 1'b0}, '{5'd1, 1'b0}, '{5'd2, 1'b1}, '{5'd4, 1'b1},
                  '{5'd9, 1'b1}, '{5'd16, 1'b0}, '{5'd20, 1'b1}, '{5'd31, 1'b1}};
    dead_vecs = '{'{5'd0, 1'b1}, '{5'd4, 1'b0}, '{5'd8, 1'b0}, '{5'd12, 1'b1},
                  '{5'd16, 1'b1}, '{5'd20, 1'b0}, '{5'd24, 1'b0}, '{5'd31, 1'b1}};

    // Reset state.
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.ce    = 1'b0;
    bus.cdi   = 1'b0;
    bus.adr   = 5'd2;
    model_reset();
    #12;
    check_all();
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_cdo",  bus.cdo,  InitVal[31]);
    rst_n = 1'b1;
    #1;
    chk("oq_after_release", bus.oq, 1'b0);

    for (int i = 0; i < 8; i++) begin
      bus.adr = init_vecs[i].adr;
      #1;
      chk("init_lut", bus.o, init_vecs[i].exp_o);
    end

    // OQ follows O one edge later.
    bus.adr = 5'd1;
    tick();
    chk("oq_adr1", bus.oq, 1'b0);
    bus.adr = 5'd4;
    tick();
    chk("oq_adr4", bus.oq, 1'b1);

    // Full frame, CE held high.
    send_frame(32'hDEADBEEF, 0, bcyc, dcyc, scyc);
    chk_int("busy_cycles_ce1", bcyc, 33);
    chk_int("done_cycles_ce1", dcyc, 1);
    chk_int("shift_cycles_ce1", scyc, 32);
    for (int i = 0; i < 8; i++) begin
      bus.adr = dead_vecs[i].adr;
      #1;
      chk("dead_lut", bus.o, dead_vecs[i].exp_o);
    end

    // Clear, then same frame with CE low every other cycle.
    send_frame(32'h0000_0000, 0, bcyc, dcyc, scyc);
    send_frame(32'hDEADBEEF, 1, bcyc, dcyc, scyc);
    chk_int("shift_cycles_gap", scyc, 64);
    chk_int("busy_cycles_gap", bcyc, 65);
    chk_int("done_cycles_gap", dcyc, 1);
    for (int i = 0; i < 8; i++) begin
      bus.adr = dead_vecs[i].adr;
      #1;
      chk("dead_lut_gap", bus.o, dead_vecs[i].exp_o);
    end

    // START held high throughout: ignored in SHIFT/COMMIT, retaken in the first IDLE cycle.
    bus.start = 1'b1;
    bus.ce    = 1'b1;
    idle_seen = 0;
    done_seen = 0;
    for (int c = 0; c < 70; c++) begin
      bus.cdi = 1'($urandom_range(0, 1));
      tick();
      if (!bus.busy) idle_seen++;
      if (bus.done) done_seen++;
    end
    chk_int("held_start_idle", idle_seen, 2);
    chk_int("held_start_done", done_seen, 2);
    bus.start = 1'b0;
    for (int c = 0; c < 80 && m_bits >= 0; c++) tick();
    idle_seen = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (!bus.busy) idle_seen++;
    end
    chk_int("no_extra_frame", idle_seen, 4);

    // Reset after 17 bits discards the partial frame.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.ce    = 1'b1;
    for (int c = 0; c < 17; c++) begin
      bus.cdi = 1'b1;
      tick();
    end
    bus.ce = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("midrst_busy", bus.busy, 1'b0);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.adr = init_vecs[i].adr;
      #1;
      chk("midrst_lut", bus.o, init_vecs[i].exp_o);
    end
    send_frame(32'hA5C3_0F96, 0, bcyc, dcyc, scyc);
    chk_int("post_rst_busy", bcyc, 33);
    for (int a = 0; a < 32; a++) begin
      bus.adr = 5'(a);
      #1;
      chk("post_rst_lut", bus.o, ref_lookup(32'hA5C3_0F96, 5'(a)));
    end

    // Unknown address bits.
    send_frame(32'h0000FFFF, 0, bcyc, dcyc, scyc);
    xadr    = 5'bx0000;
    bus.adr = xadr;
    #1;
    chk("x_adr4", bus.o, ref_lookup(32'h0000FFFF, xadr));
    bus.adr = 5'd0;
    send_frame(32'hFFFFFFFF, 0, bcyc, dcyc, scyc);
    bus.adr = 5'b0x000;
    #1;
    chk("x_adr3_all1", bus.o, 1'b1);
    bus.adr = 5'd0;
    send_frame(32'h00FF00FF, 0, bcyc, dcyc, scyc);
    bus.adr = 5'b0000x;
    #1;
    chk("x_adr0", bus.o, 1'b1);
    bus.adr = 5'd0;

    // Random frames with random CE, stray START pulses and idle gaps.
    for (int f = 0; f < 8; f++) begin
      rdata = $urandom;
      send_frame(rdata, 2, bcyc, dcyc, scyc);
      chk_int("rand_done", dcyc, 1);
      for (int c = 0; c < int'($urandom_range(0, 3)); c++) begin
        bus.adr = 5'($urandom_range(0, 31));
        tick();
      end
      bus.adr = 5'($urandom_range(0, 31));
      #1;
      chk("rand_lut", bus.o, rdata[bus.adr]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
